// File: rtl/aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_core
// Purpose  : Iterative AES-128 inverse cipher, one decryption round per clock.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_core #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      ct_in,
  input  logic              ct_valid,
  output logic              ct_ready,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      round_key,
  output logic [127:0]      pt_out,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic              busy
);

  // Inverse S-box, entry x at bits [2047-8x -: 8].
  localparam logic [2047:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] f_inv_sbox(input logic [7:0] x);
    return c_inv_sbox[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] f_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant whose bits select a, 2a, 4a, 8a.
  function automatic logic [7:0] f_gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] m2, m4, m8;
    m2 = f_xtime(a);
    m4 = f_xtime(m2);
    m8 = f_xtime(m4);
    return (k[3] ? m8 : 8'h00) ^ (k[2] ? m4 : 8'h00) ^ (k[1] ? m2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [127:0] f_inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*((c + r) % 4) + r) -: 8] = s[127 - 8*(4*c + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] f_inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = f_inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] f_inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = f_gf_mul(a0, 4'he) ^ f_gf_mul(a1, 4'hb) ^ f_gf_mul(a2, 4'hd) ^ f_gf_mul(a3, 4'h9);
      o[119 - 32*c -: 8] = f_gf_mul(a0, 4'h9) ^ f_gf_mul(a1, 4'he) ^ f_gf_mul(a2, 4'hb) ^ f_gf_mul(a3, 4'hd);
      o[111 - 32*c -: 8] = f_gf_mul(a0, 4'hd) ^ f_gf_mul(a1, 4'h9) ^ f_gf_mul(a2, 4'he) ^ f_gf_mul(a3, 4'hb);
      o[103 - 32*c -: 8] = f_gf_mul(a0, 4'hb) ^ f_gf_mul(a1, 4'hd) ^ f_gf_mul(a2, 4'h9) ^ f_gf_mul(a3, 4'he);
    end
    return o;
  endfunction

  state_t             r_fsm;
  logic [KIDX_W-1:0]  r_cnt;
  logic [127:0]       r_state;
  logic [127:0]       r_pt;
  logic               r_pt_valid;
  logic               r_ct_ready;
  logic               r_busy;

  logic [127:0]       w_isr;
  logic [127:0]       w_isb;
  logic [127:0]       w_ark;
  logic [127:0]       w_imc;

  assign w_isr = f_inv_shift_rows(r_state);
  assign w_isb = f_inv_sub_bytes(w_isr);
  assign w_ark = w_isb ^ round_key;
  assign w_imc = f_inv_mix_columns(w_ark);

  // The counter doubles as key_idx, so the index only changes on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_cnt      <= KIDX_W'(NR);
      r_state    <= '0;
      r_pt       <= '0;
      r_pt_valid <= 1'b0;
      r_ct_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (ct_valid && r_ct_ready) begin
            r_state    <= ct_in ^ round_key;
            r_cnt      <= KIDX_W'(NR - 1);
            r_ct_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= w_imc;
          r_cnt   <= r_cnt - KIDX_W'(1);
          if (r_cnt == KIDX_W'(1)) begin
            r_fsm <= S_FINAL;
          end
        end
        S_FINAL: begin
          r_pt       <= w_ark;
          r_pt_valid <= 1'b1;
          r_cnt      <= KIDX_W'(NR);
          r_fsm      <= S_DONE;
        end
        S_DONE: begin
          if (pt_ready) begin
            r_pt_valid <= 1'b0;
            r_ct_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_fsm      <= S_IDLE;
          end
        end
        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign ct_ready = r_ct_ready;
  assign busy     = r_busy;
  assign key_idx  = r_cnt;
  assign pt_out   = r_pt;
  assign pt_valid = r_pt_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_cipher_core
// Purpose  : Directed and round-trip checks of the AES-128 inverse cipher core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_core;

  localparam logic [127:0] c_key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_pt  = 128'h00112233445566778899aabbccddeeff;

  logic         clk;
  logic         rst;
  logic [127:0] ct_in;
  logic         ct_valid;
  logic         ct_ready;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] pt_out;
  logic         pt_valid;
  logic         pt_ready;
  logic         busy;

  logic [127:0] rk [16];
  logic [7:0]   sb [256];
  int           n_chk;
  int           n_err;

  aes_inv_cipher_core #(.NR(10), .KIDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ct_in     (ct_in),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready),
    .key_idx   (key_idx),
    .round_key (round_key),
    .pt_out    (pt_out),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb round_key = rk[key_idx];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Forward S-box from its definition: GF inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int k = 1; k < 256; k++) begin
        if (gmul(8'(x), 8'(k)) == 8'h01) inv = 8'(k);
      end
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk[r] = '0;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] st;
    st = pt ^ rk[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[st[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c + w] = s[4*((c + w) % 4) + w];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = s[i];
      st = st ^ rk[rnd];
    end
    return st;
  endfunction

  // Cycle 0 is the acceptance cycle; pt_valid is expected in cycle 11.
  task automatic run_decrypt(input logic [127:0] ct, input logic [127:0] exp_pt,
                             input bit chk_keys, input bit chk_int, input string tag);
    int lat;
    int w;
    @(negedge clk);
    ct_in    = ct;
    ct_valid = 1'b1;
    w = 0;
    while (!ct_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!ct_ready) begin
      check_eq({tag, "_accept_timeout"}, 128'd0, 128'd1);
      ct_valid = 1'b0;
      return;
    end
    if (chk_keys) check_eq({tag, "_kidx"}, 128'(key_idx), 128'd10);
    @(negedge clk);
    ct_valid = 1'b0;
    lat = 1;
    if (chk_int) begin
      check_eq({tag, "_state0"}, dut.r_state, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
      check_eq({tag, "_isr"}, dut.w_isr, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);
      check_eq({tag, "_isb"}, dut.w_isb, 128'hbd6e7c3df2b5779e0b61216e8b10b689);
    end
    while (!pt_valid && lat < 30) begin
      if (chk_keys && lat <= 10) check_eq({tag, "_kidx"}, 128'(key_idx), 128'(10 - lat));
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'd11);
    check_eq({tag, "_pt"}, pt_out, exp_pt);
  endtask

  initial begin
    int nout, t, acc0, acc1, npv;
    logic [127:0] key, pt, ct;
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    ct_in    = '0;
    ct_valid = 1'b0;
    pt_ready = 1'b0;
    build_sbox();
    expand_key(c_key);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_pt_out", pt_out, 128'd0);
    check_eq("rst_pt_valid", 128'(pt_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_ct_ready", 128'(ct_ready), 128'd1);
    check_eq("rst_kidx", 128'(key_idx), 128'd10);
    check_eq("rst_state", dut.r_state, 128'd0);

    pt_ready = 1'b1;
    run_decrypt(c_ct, c_pt, 1'b1, 1'b1, "c1");
    @(negedge clk);
    check_eq("c1_idle_ready", 128'(ct_ready), 128'd1);
    check_eq("c1_valid_drop", 128'(pt_valid), 128'd0);
    check_eq("c1_pt_kept", pt_out, c_pt);

    // Backpressure with a stray block offered while the result is held.
    pt_ready = 1'b0;
    run_decrypt(c_ct, c_pt, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 128'(pt_valid), 128'd1);
      check_eq("bp_pt", pt_out, c_pt);
      check_eq("bp_ct_ready", 128'(ct_ready), 128'd0);
      if (i == 4) begin
        ct_in    = 128'hdeadbeef0123456789abcdeffedcba98;
        ct_valid = 1'b1;
      end
      if (i == 6) ct_valid = 1'b0;
    end
    pt_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_rel_ready", 128'(ct_ready), 128'd1);
    check_eq("bp_rel_valid", 128'(pt_valid), 128'd0);
    check_eq("bp_rel_busy", 128'(busy), 128'd0);

    // Back-to-back with ct_valid held high.
    ct_in    = c_ct;
    ct_valid = 1'b1;
    nout = 0; t = 0; acc0 = -1; acc1 = -1;
    while (nout < 2 && t < 60) begin
      if (ct_valid && ct_ready) begin
        if (acc0 < 0) acc0 = t;
        else if (acc1 < 0) acc1 = t;
      end
      if (pt_valid) begin
        nout++;
        check_eq("b2b_pt", pt_out, c_pt);
        if (nout == 2) ct_valid = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    ct_valid = 1'b0;
    check_eq("b2b_outputs", 128'(nout), 128'd2);
    check_eq("b2b_ii", 128'(acc1 - acc0), 128'd12);

    // Asynchronous reset in the fifth ROUND cycle.
    ct_in    = c_ct;
    ct_valid = 1'b1;
    @(negedge clk);
    ct_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_busy_before", 128'(busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_busy", 128'(busy), 128'd0);
    check_eq("mid_pt_valid", 128'(pt_valid), 128'd0);
    check_eq("mid_ct_ready", 128'(ct_ready), 128'd1);
    check_eq("mid_kidx", 128'(key_idx), 128'd10);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    npv = 0;
    repeat (15) begin
      @(negedge clk);
      if (pt_valid) npv++;
    end
    check_eq("mid_no_pulse", 128'(npv), 128'd0);
    run_decrypt(c_ct, c_pt, 1'b1, 1'b0, "post_rst");

    for (int n = 0; n < 100; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      ct = aes_enc(pt);
      run_decrypt(ct, pt, 1'b0, 1'b0, "rt");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
